mod_fsm_bank: RTL

Bank of CH independent Moore state machines, each a modulo-MOD state counter. A channel advances one state when a qualified input of 0 arrives and holds when the input is 1. It asserts its output while in a programmable output state. With CH=1, MOD=2, RST_STATE=1, OUT_STATE=1 and `in_valid` tied high, it is the two-state toggle machine. It sits in the verilogmachine FSM family as the parametrised generation, and testbenches compare it against a behavioural model on both clock edges.

---
 rtl/mod_fsm_bank_pkg.sv | 29 ++
 rtl/mod_fsm_chan.sv | 71 +++++++
 rtl/mod_fsm_bank.sv | 51 +++++
 3 files changed

// File: rtl/mod_fsm_bank_pkg.sv
// rtl/mod_fsm_bank_pkg.sv - defaults, channel action type and state helpers for mod_fsm_bank
package mod_fsm_bank_pkg;

    localparam int DEF_CH        = 4;
    localparam int DEF_MOD       = 2;
    localparam int DEF_RST_STATE = 1;
    localparam int DEF_OUT_STATE = 1;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_ADVANCE,
        ACT_CLEAR,
        ACT_RESET
    } chan_act_e;

    function automatic int state_w(input int mod);
        return (mod <= 2) ? 1 : $clog2(mod);
    endfunction

    // Anything at or above MOD-1 wraps to 0, so an illegal encoding recovers on its next advance.
    function automatic logic [31:0] next_state(input logic [31:0] state, input int unsigned mod);
        if (state >= (mod - 32'd1)) begin
            return '0;
        end
        return state + 32'd1;
    endfunction

endpackage

// File: rtl/mod_fsm_chan.sv
// rtl/mod_fsm_chan.sv - one modulo-MOD Moore channel with out decode
// Entry counter is built only when MOD_FSM_BANK_ENTRY_CNT_EN is defined.
module mod_fsm_chan
    import mod_fsm_bank_pkg::*;
#(
    parameter int MOD       = DEF_MOD,
    parameter int RST_STATE = DEF_RST_STATE,
    parameter int OUT_STATE = DEF_OUT_STATE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clear,
    output logic             out,
    output logic [CNT_W-1:0] entry_cnt
);

    localparam int            SW      = state_w(MOD);
    localparam logic [SW-1:0] RST_ENC = SW'(RST_STATE);
    localparam logic [SW-1:0] OUT_ENC = SW'(OUT_STATE);

    chan_act_e     act;
    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;

    always_comb begin
        act = ACT_HOLD;
        if (reset) begin
            act = ACT_RESET;
        end else if (clear) begin
            act = ACT_CLEAR;
        end else if (in_valid && !in) begin
            act = ACT_ADVANCE;
        end
    end

    assign state_nxt = SW'(next_state(32'(state), MOD));

    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET, ACT_CLEAR: state <= RST_ENC;
            ACT_ADVANCE:          state <= state_nxt;
            default:              state <= state;
        endcase
    end

    assign out = (state == OUT_ENC);

`ifdef MOD_FSM_BANK_ENTRY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Only an advance landing on OUT_STATE counts; reset/clear entries are not entries.
    always_ff @(posedge clk) begin
        if (act == ACT_RESET || act == ACT_CLEAR) begin
            cnt <= '0;
        end else if (act == ACT_ADVANCE && state_nxt == OUT_ENC &&
                     state != OUT_ENC && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign entry_cnt = cnt;
`else
    assign entry_cnt = '0;
`endif

endmodule

// File: rtl/mod_fsm_bank.sv
// rtl/mod_fsm_bank.sv - bank of CH independent modulo-MOD Moore channels
// Optional per-channel entry counters via MOD_FSM_BANK_ENTRY_CNT_EN.
module mod_fsm_bank
    import mod_fsm_bank_pkg::*;
#(
    parameter int CH        = DEF_CH,
    parameter int MOD       = DEF_MOD,
    parameter int RST_STATE = DEF_RST_STATE,
    parameter int OUT_STATE = DEF_OUT_STATE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       in,
    input  logic [CH-1:0]       in_valid,
    input  logic [CH-1:0]       clear,
    output logic [CH-1:0]       out,
    output logic                any_out,
    output logic                all_out,
    output logic [CH*CNT_W-1:0] entry_cnt
);

    generate
        if (CH < 1 || MOD < 2 || CNT_W < 1 ||
            RST_STATE < 0 || RST_STATE >= MOD ||
            OUT_STATE < 0 || OUT_STATE >= MOD) begin : g_bad_cfg
            $error("mod_fsm_bank: illegal parameter set");
        end
    endgenerate

    for (genvar i = 0; i < CH; i++) begin : g_chan
        mod_fsm_chan #(
            .MOD       (MOD),
            .RST_STATE (RST_STATE),
            .OUT_STATE (OUT_STATE),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .in        (in[i]),
            .in_valid  (in_valid[i]),
            .clear     (clear[i]),
            .out       (out[i]),
            .entry_cnt (entry_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign any_out = |out;
    assign all_out = &out;

endmodule
